// File: rtl/wb_stage.sv
// Write-back select stage: picks the register-file write datum (imm, ALU, link, load),
// aligns and extends loads, and registers the result under flush/stall control.
module wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned PC_INC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              m_valid,
  input  logic              m_rf_we,
  input  logic [REG_AW-1:0] m_rd,
  input  logic [1:0]        m_wd_sel,
  input  logic [2:0]        m_funct3,
  input  logic [2:0]        m_addr_lo,
  input  logic [DATA_W-1:0] m_sext,
  input  logic [DATA_W-1:0] m_alu_c,
  input  logic [DATA_W-1:0] m_pc,
  input  logic [DATA_W-1:0] m_dram_rd,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_wd
);

  localparam int unsigned N_B = DATA_W / 8;
  localparam int unsigned N_H = DATA_W / 16;
  localparam int unsigned N_W = DATA_W / 32;

  logic [2:0]        off;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_w;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] sel_data;

  // Lane extraction; misaligned offsets fall to the natural boundary.
  always_comb begin
    off  = (DATA_W == 64) ? m_addr_lo : {1'b0, m_addr_lo[1:0]};
    ld_b = '0;
    ld_h = '0;
    ld_w = '0;
    for (int unsigned i = 0; i < N_B; i++)
      if (off == 3'(i)) ld_b = m_dram_rd[8*i +: 8];
    for (int unsigned i = 0; i < N_H; i++)
      if (off[2:1] == 2'(i)) ld_h = m_dram_rd[16*i +: 16];
    for (int unsigned i = 0; i < N_W; i++)
      if (off[2] == 1'(i)) ld_w = m_dram_rd[32*i +: 32];
  end

  // Extension by load type; word/doubleword forms collapse to the full word on RV32.
  always_comb begin
    ld_data = m_dram_rd;
    case (m_funct3)
      3'b000:  ld_data = DATA_W'($signed(ld_b));
      3'b100:  ld_data = DATA_W'(ld_b);
      3'b001:  ld_data = DATA_W'($signed(ld_h));
      3'b101:  ld_data = DATA_W'(ld_h);
      3'b010:  ld_data = DATA_W'($signed(ld_w));
      3'b110:  ld_data = DATA_W'(ld_w);
      default: ld_data = m_dram_rd;
    endcase
  end

  always_comb begin
    sel_data = m_sext;
    case (m_wd_sel)
      2'b00:   sel_data = m_sext;
      2'b01:   sel_data = m_alu_c;
      2'b10:   sel_data = m_pc + DATA_W'(PC_INC);
      default: sel_data = ld_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_wd    <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_wd    <= '0;
    end else if (!stall) begin
      wb_valid <= m_valid;
      wb_we    <= m_valid & m_rf_we & (m_rd != '0);
      wb_rd    <= m_rd;
      wb_wd    <= sel_data;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: RV32 and RV64 instances share control inputs;
// expected results are queued at drive time and checked one edge later.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic        m_valid, m_rf_we;
  logic [4:0]  m_rd;
  logic [1:0]  m_wd_sel;
  logic [2:0]  m_funct3, m_addr_lo;
  logic [63:0] sx, alu, pc, dr;

  logic        v32, we32, v64, we64;
  logic [4:0]  rd32, rd64;
  logic [31:0] wd32;
  logic [63:0] wd64;

  typedef struct {
    string       tag;
    bit          is64;
    logic        v;
    logic        we;
    logic [4:0]  rd;
    logic [63:0] wd;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(32), .REG_AW(5), .PC_INC(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_rf_we(m_rf_we), .m_rd(m_rd), .m_wd_sel(m_wd_sel),
    .m_funct3(m_funct3), .m_addr_lo(m_addr_lo),
    .m_sext(sx[31:0]), .m_alu_c(alu[31:0]), .m_pc(pc[31:0]), .m_dram_rd(dr[31:0]),
    .wb_valid(v32), .wb_we(we32), .wb_rd(rd32), .wb_wd(wd32)
  );

  wb_stage #(.DATA_W(64), .REG_AW(5), .PC_INC(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_rf_we(m_rf_we), .m_rd(m_rd), .m_wd_sel(m_wd_sel),
    .m_funct3(m_funct3), .m_addr_lo(m_addr_lo),
    .m_sext(sx), .m_alu_c(alu), .m_pc(pc), .m_dram_rd(dr),
    .wb_valid(v64), .wb_we(we64), .wb_rd(rd64), .wb_wd(wd64)
  );

  task automatic cmp(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input bit is64, input logic v, input logic we,
                      input logic [4:0] rd, input logic [63:0] wd);
    exp_t e;
    e.tag = tag; e.is64 = is64; e.v = v; e.we = we; e.rd = rd; e.wd = wd;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [2:0] f3, input logic [2:0] lo,
                       input logic [63:0] d_sx, input logic [63:0] d_alu,
                       input logic [63:0] d_pc, input logic [63:0] d_dr);
    m_valid = v; m_rf_we = we; m_rd = rd; m_wd_sel = sel; m_funct3 = f3; m_addr_lo = lo;
    sx = d_sx; alu = d_alu; pc = d_pc; dr = d_dr;
  endtask

  // Advance one edge and retire every queued expectation against its instance.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is64) begin
        cmp({e.tag, ".v64"},  64'(v64),  64'(e.v));
        cmp({e.tag, ".we64"}, 64'(we64), 64'(e.we));
        cmp({e.tag, ".rd64"}, 64'(rd64), 64'(e.rd));
        cmp({e.tag, ".wd64"}, wd64,      e.wd);
      end else begin
        cmp({e.tag, ".v32"},  64'(v32),  64'(e.v));
        cmp({e.tag, ".we32"}, 64'(we32), 64'(e.we));
        cmp({e.tag, ".rd32"}, 64'(rd32), 64'(e.rd));
        cmp({e.tag, ".wd32"}, 64'(wd32), e.wd);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, ".v32"},  64'(v32),  64'd0);
    cmp({tag, ".we32"}, 64'(we32), 64'd0);
    cmp({tag, ".rd32"}, 64'(rd32), 64'd0);
    cmp({tag, ".wd32"}, 64'(wd32), 64'd0);
    cmp({tag, ".wd64"}, wd64,      64'd0);
  endtask

  localparam logic [63:0] DR32 = 64'h0000_0000_80FF_7F01;
  localparam logic [63:0] DR64 = 64'h8000_0000_7FFF_FFFF;

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 2'b00, 3'b000, 3'b000, '0, '0, '0, '0);
    #3;
    check_zero("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in mid-cycle clears a live result before any edge.
    drive(1, 1, 5'd3, 2'b01, 3'b000, 3'b000, '0, 64'hDEAD_BEEF, '0, '0);
    push("pre_rst", 0, 1, 1, 5'd3, 64'hDEAD_BEEF);
    tick();
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    drive(1, 1, 5'd5, 2'b01, 3'b000, 3'b000, '0, 64'h1234_5678, '0, '0);
    push("alu_a", 0, 1, 1, 5'd5, 64'h1234_5678);
    tick();

    drive(1, 1, 5'd6, 2'b00, 3'b000, 3'b000, 64'hFFFF_FFFF_FFFF_F800, 64'h1, '0, '0);
    push("sext32", 0, 1, 1, 5'd6, 64'hFFFF_F800);
    push("sext64", 1, 1, 1, 5'd6, 64'hFFFF_FFFF_FFFF_F800);
    tick();

    // Link increment wraps at the datapath width.
    drive(1, 1, 5'd1, 2'b10, 3'b000, 3'b000, '0, '0, 64'hFFFF_FFFF_FFFF_FFFC, '0);
    push("link_wrap32", 0, 1, 1, 5'd1, 64'h0);
    push("link_wrap64", 1, 1, 1, 5'd1, 64'h0);
    tick();
    drive(1, 1, 5'd1, 2'b10, 3'b000, 3'b000, '0, '0, 64'h0000_1000, '0);
    push("link32", 0, 1, 1, 5'd1, 64'h0000_1004);
    tick();

    drive(1, 1, 5'd8, 2'b11, 3'b000, 3'b011, '0, '0, '0, DR32);
    push("lb_off3", 0, 1, 1, 5'd8, 64'hFFFF_FF80);
    tick();
    drive(1, 1, 5'd8, 2'b11, 3'b100, 3'b011, '0, '0, '0, DR32);
    push("lbu_off3", 0, 1, 1, 5'd8, 64'h0000_0080);
    tick();
    drive(1, 1, 5'd8, 2'b11, 3'b000, 3'b001, '0, '0, '0, DR32);
    push("lb_off1", 0, 1, 1, 5'd8, 64'h0000_007F);
    tick();
    drive(1, 1, 5'd8, 2'b11, 3'b001, 3'b010, '0, '0, '0, DR32);
    push("lh_off2", 0, 1, 1, 5'd8, 64'hFFFF_80FF);
    tick();
    drive(1, 1, 5'd8, 2'b11, 3'b101, 3'b011, '0, '0, '0, DR32);
    push("lhu_off3", 0, 1, 1, 5'd8, 64'h0000_80FF);
    tick();
    drive(1, 1, 5'd8, 2'b11, 3'b010, 3'b000, '0, '0, '0, DR32);
    push("lw32", 0, 1, 1, 5'd8, 64'h80FF_7F01);
    tick();

    drive(1, 1, 5'd9, 2'b11, 3'b010, 3'b100, '0, '0, '0, DR64);
    push("lw_off4_64", 1, 1, 1, 5'd9, 64'hFFFF_FFFF_8000_0000);
    push("lw_addr2_ign32", 0, 1, 1, 5'd9, 64'h7FFF_FFFF);
    tick();
    drive(1, 1, 5'd9, 2'b11, 3'b110, 3'b100, '0, '0, '0, DR64);
    push("lwu_off4_64", 1, 1, 1, 5'd9, 64'h0000_0000_8000_0000);
    tick();
    drive(1, 1, 5'd9, 2'b11, 3'b011, 3'b000, '0, '0, '0, DR64);
    push("ld64", 1, 1, 1, 5'd9, DR64);
    tick();
    drive(1, 1, 5'd9, 2'b11, 3'b001, 3'b111, '0, '0, '0, DR64);
    push("lh_off7_64", 1, 1, 1, 5'd9, 64'hFFFF_FFFF_FFFF_8000);
    tick();

    // Stall holds A through changing inputs, then flush beats stall.
    drive(1, 1, 5'd10, 2'b01, 3'b000, 3'b000, '0, 64'hA5A5_0001, '0, '0);
    push("cap_a", 0, 1, 1, 5'd10, 64'hA5A5_0001);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'(i), 1, 5'(20 + i), 2'b01, 3'b000, 3'b000, '0, 64'(i * 7 + 3), '0, '0);
      push($sformatf("stall%0d", i), 0, 1, 1, 5'd10, 64'hA5A5_0001);
      tick();
    end
    flush = 1'b1;
    push("flush_stall32", 0, 0, 0, 5'd0, 64'h0);
    push("flush_stall64", 1, 0, 0, 5'd0, 64'h0);
    tick();
    stall = 1'b0;
    flush = 1'b0;
    drive(1, 1, 5'd11, 2'b01, 3'b000, 3'b000, '0, 64'h0BAD_F00D, '0, '0);
    push("cap_b", 0, 1, 1, 5'd11, 64'h0BAD_F00D);
    tick();

    drive(1, 1, 5'd0, 2'b01, 3'b000, 3'b000, '0, 64'h55, '0, '0);
    push("x0_write", 0, 1, 0, 5'd0, 64'h55);
    tick();
    drive(0, 1, 5'd7, 2'b01, 3'b000, 3'b000, '0, 64'h77, '0, '0);
    push("bubble", 0, 0, 0, 5'd7, 64'h77);
    tick();
    drive(1, 0, 5'd7, 2'b01, 3'b000, 3'b000, '0, 64'h78, '0, '0);
    push("no_we", 0, 1, 0, 5'd7, 64'h78);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
